// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-only data memory: turns byte/half/word
// requests into word read/write cycles, with read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  input  logic [DATA_W-1:0] mem_readData
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              write_q;
  logic              unsigned_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wr_word_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_error_q;

  logic              accept;
  logic              req_bad;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merged;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    req_bad = 1'b0;
    case (req_size)
      SZ_HALF: req_bad = req_addr[0];
      SZ_WORD: req_bad = (req_addr[1:0] != 2'b00);
      SZ_BAD:  req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)                              next_state = RESP;
          else if (req_write && req_size == SZ_WORD) next_state = WR;
          else                                      next_state = RD;
        end
      end
      RD:      next_state = write_q ? WR : RESP;
      WR:      next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Little-endian lane select and extension of the word read from memory.
  always_comb begin
    sel_byte = mem_readData[7:0];
    case (addr_q[1:0])
      2'd1:    sel_byte = mem_readData[15:8];
      2'd2:    sel_byte = mem_readData[23:16];
      2'd3:    sel_byte = mem_readData[31:24];
      default: sel_byte = mem_readData[7:0];
    endcase
    sel_half = addr_q[1] ? mem_readData[31:16] : mem_readData[15:0];

    load_ext = mem_readData;
    case (size_q)
      SZ_BYTE: load_ext = {{24{sel_byte[7] & ~unsigned_q}}, sel_byte};
      SZ_HALF: load_ext = {{16{sel_half[15] & ~unsigned_q}}, sel_half};
      default: load_ext = mem_readData;
    endcase
  end

  // Read-modify-write merge: only the addressed lane takes the store data.
  always_comb begin
    merged = mem_readData;
    if (size_q == SZ_BYTE) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clock_in) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      addr_q       <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      wdata_q      <= '0;
      wr_word_q    <= '0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr;
        size_q     <= req_size;
        write_q    <= req_write;
        unsigned_q <= req_unsigned;
        wdata_q    <= req_wdata;
        if (req_write && req_size == SZ_WORD) wr_word_q <= req_wdata;
      end
      if (state == RD && write_q) wr_word_q <= merged;

      // Response registers change only on entry to RESP, so they hold otherwise.
      if (next_state == RESP && state != RESP) begin
        resp_error_q <= (state == IDLE);
        resp_rdata_q <= (state == RD && !write_q) ? load_ext : '0;
      end
    end
  end

  assign req_ready     = (state == IDLE);
  assign resp_valid    = (state == RESP);
  assign resp_rdata    = resp_rdata_q;
  assign resp_error    = resp_error_q;
  assign mem_memRead   = (state == RD);
  assign mem_memWrite  = (state == WR);
  assign mem_address   = {2'b00, addr_q[ADDR_W-1:2]};
  assign mem_writeData = wr_word_q;

endmodule
